// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump reader: FSM state encoding
// and the default widths used when the top is instantiated without overrides.
package regfile_dump_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        CSUM = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a register range through one combinational read port and streams {index, data}
// over valid/ready. Define REGFILE_DUMP_CSUM_EN to append a trailing XOR checksum word.
module regfile_dump_reader
    import regfile_dump_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_idx,
    input  logic [ADDR_WIDTH-1:0] last_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_is_csum
);

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] last;
    logic                  load;
    logic                  finish;
    logic                  reject;
    logic                  hs;
    logic                  at_last;

`ifdef REGFILE_DUMP_CSUM_EN
    logic [DATA_WIDTH-1:0] csum;
    logic                  csum_word;
    assign out_is_csum = csum_word;
`else
    assign out_is_csum = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign out_valid = (state == SEND) || (state == CSUM);
    assign hs        = out_valid && out_ready;
    assign at_last   = (idx == last);
    assign rd_addr   = idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        finish     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (first_idx <= last_idx) begin
                        load       = 1'b1;
                        next_state = READ;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            READ: next_state = SEND;
            SEND: begin
                if (hs) begin
                    if (!at_last) begin
                        next_state = READ;
                    end else begin
`ifdef REGFILE_DUMP_CSUM_EN
                        next_state = CSUM;
`else
                        next_state = IDLE;
                        finish     = 1'b1;
`endif
                    end
                end
            end
            CSUM: begin
                if (hs) begin
                    next_state = IDLE;
                    finish     = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output holding stage: loaded in READ, frozen through SEND until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            last     <= '0;
            out_idx  <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef REGFILE_DUMP_CSUM_EN
            csum      <= '0;
            csum_word <= 1'b0;
`endif
        end else begin
            done <= finish || reject;
            err  <= reject;
            if (load) begin
                idx  <= first_idx;
                last <= last_idx;
`ifdef REGFILE_DUMP_CSUM_EN
                csum <= '0;
`endif
            end
            if (state == READ) begin
                out_idx  <= idx;
                out_data <= rd_data;
`ifdef REGFILE_DUMP_CSUM_EN
                out_last  <= 1'b0;
                csum_word <= 1'b0;
`else
                out_last <= at_last;
`endif
            end
            // Counter stops on the last index so a range ending at the top never wraps.
            if ((state == SEND) && hs) begin
                if (!at_last) begin
                    idx <= idx + 1'b1;
                end
`ifdef REGFILE_DUMP_CSUM_EN
                csum <= csum ^ out_data;
                if (at_last) begin
                    out_idx   <= '0;
                    out_data  <= csum ^ out_data;
                    out_last  <= 1'b1;
                    csum_word <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a queue-based word model built from the
// register contents, directed boundary tests, then randomized ranges and back-pressure.
module tb_regfile_dump_reader;

`ifdef REGFILE_DUMP_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
        logic        csum;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_is_csum;

    logic [31:0] regs [32];
    word_t       exp_q[$];
    logic [31:0] acc_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_count = 0;
    int          ready_mode = 0;
    int          stall_left = 0;

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    regfile_dump_reader dut (
        .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .last_idx(last_idx),
        .busy(busy), .done(done), .err(err), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
        .out_last(out_last), .out_is_csum(out_is_csum)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected word stream for an accepted range, straight from the register contents.
    task automatic buildModel(input logic [4:0] f, input logic [4:0] l);
        word_t       w;
        logic [31:0] x;
        x = '0;
        for (int i = int'(f); i <= int'(l); i++) begin
            w.idx  = 5'(i);
            w.data = regs[i];
            w.last = (i == int'(l)) && !CSUM_ON;
            w.csum = 1'b0;
            x      = x ^ regs[i];
            exp_q.push_back(w);
        end
        if (CSUM_ON) begin
            w.idx  = '0;
            w.data = x;
            w.last = 1'b1;
            w.csum = 1'b1;
            exp_q.push_back(w);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] f, input logic [4:0] l);
        int   waited;
        logic prev_hs;
        @(posedge clk); #1;
        if (f <= l) buildModel(f, l);
        first_idx = f;
        last_idx  = l;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        first_idx = 5'($urandom);
        last_idx  = 5'($urandom);
        @(negedge clk);
        if (f > l) begin
            checkOutput("reject_done", done, 1);
            checkOutput("reject_err", err, 1);
            checkOutput("reject_busy", busy, 0);
            checkOutput("reject_valid", out_valid, 0);
            @(negedge clk);
            checkOutput("reject_done_pulse", done, 0);
            checkOutput("reject_busy_after", busy, 0);
        end else begin
            checkOutput("read_busy", busy, 1);
            checkOutput("read_no_valid", out_valid, 0);
            @(negedge clk);
            checkOutput("first_valid_latency", out_valid, 1);
            waited  = 0;
            prev_hs = out_valid && out_ready;
            while (!done && waited < 3000) begin
                prev_hs = out_valid && out_ready;
                @(negedge clk);
                waited++;
            end
            if (!done) begin
                checks++;
                errors++;
                $display("[TB] FAIL done_timeout actual=no_done required=done range=%0d..%0d", f, l);
            end else begin
                checkOutput("done_after_last_hs", prev_hs, 1);
                checkOutput("done_err", err, 0);
                checkOutput("done_busy", busy, 0);
                checkOutput("queue_drained", exp_q.size(), 0);
                @(negedge clk);
                checkOutput("done_pulse", done, 0);
            end
        end
    endtask

    // Sink ready driver: always ready, random back-pressure, or a 3-cycle stall on idx 6.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) begin
                out_ready = 1'b1;
            end else if (ready_mode == 1) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else if (out_valid && out_idx == 5'd6 && !out_is_csum && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Compare process: every presented word must match the model head until it is accepted.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done) done_count++;
                if (out_valid) begin
                    checkOutput("busy_with_valid", busy, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL extra_word actual_idx=%0h actual_data=%0h required=none",
                                 out_idx, out_data);
                    end else begin
                        checkOutput("word_idx", out_idx, exp_q[0].idx);
                        checkOutput("word_data", out_data, exp_q[0].data);
                        checkOutput("word_last", out_last, exp_q[0].last);
                        checkOutput("word_is_csum", out_is_csum, exp_q[0].csum);
                        if (out_ready) begin
                            acc_q.push_back(out_data);
                            void'(exp_q.pop_front());
                        end
                    end
                end else begin
                    checkOutput("csum_flag_idle", out_is_csum && !CSUM_ON, 0);
                end
            end
        end
    end

    initial begin
        int dc0;
        rst       = 1'b1;
        start     = 1'b0;
        first_idx = '0;
        last_idx  = '0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_last", out_last, 0);
        checkOutput("rst_csum", out_is_csum, 0);
        checkOutput("rst_rd_addr", rd_addr, 0);
        checkOutput("rst_out_idx", out_idx, 0);
        checkOutput("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic dump 5..8 with literal pins on what the sink received.
        regs[5] = 32'h11; regs[6] = 32'h22; regs[7] = 32'h44; regs[8] = 32'h88;
        acc_q.delete();
        applyStimulus(5'd5, 5'd8);
        checkOutput("t1_count", acc_q.size(), CSUM_ON ? 5 : 4);
        if (acc_q.size() >= 4) begin
            checkOutput("t1_w5", acc_q[0], 32'h11);
            checkOutput("t1_w6", acc_q[1], 32'h22);
            checkOutput("t1_w7", acc_q[2], 32'h44);
            checkOutput("t1_w8", acc_q[3], 32'h88);
        end
        if (CSUM_ON && acc_q.size() >= 5) checkOutput("t1_csum", acc_q[4], 32'hFF);

        // Same dump with the sink stalling for 3 cycles on idx 6.
        acc_q.delete();
        stall_left = 3;
        ready_mode = 2;
        applyStimulus(5'd5, 5'd8);
        ready_mode = 0;
        checkOutput("t2_stall_used", stall_left, 0);
        checkOutput("t2_count", acc_q.size(), CSUM_ON ? 5 : 4);
        if (acc_q.size() >= 4) checkOutput("t2_w6", acc_q[1], 32'h22);

        // Reversed range is rejected.
        applyStimulus(5'd9, 5'd3);

        // Single top register: one word and no wrap of the index.
        regs[31] = 32'hDEADBEEF;
        acc_q.delete();
        applyStimulus(5'd31, 5'd31);
        checkOutput("t4_count", acc_q.size(), CSUM_ON ? 2 : 1);
        if (acc_q.size() >= 1) checkOutput("t4_data", acc_q[0], 32'hDEADBEEF);
        checkOutput("t4_no_wrap", rd_addr, 5'd31);

        // Second start while busy is ignored; reset mid-dump aborts with no done.
        @(posedge clk); #1;
        buildModel(5'd2, 5'd20);
        first_idx = 5'd2; last_idx = 5'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        first_idx = 5'd0; last_idx = 5'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        dc0 = done_count;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_valid", out_valid, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_last", out_last, 0);
        checkOutput("abort_out_data", out_data, 0);
        checkOutput("abort_out_idx", out_idx, 0);
        checkOutput("abort_rd_addr", rd_addr, 0);
        repeat (5) @(negedge clk);
        checkOutput("abort_no_done", done_count, dc0);
        checkOutput("abort_still_idle", busy, 0);

        // Randomized ranges, contents and back-pressure.
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            ready_mode = $urandom_range(0, 1);
            applyStimulus(5'($urandom), 5'($urandom));
        end
        ready_mode = 0;

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
